// File: rtl/l2cache_mem_responder.sv
// rtl/l2cache_mem_responder.sv - L2 refill/writeback responder
// Turns L2 line/word read and write requests into word accesses on a single-outstanding RAM port.
module l2cache_mem_responder #(
  parameter int offset_width = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            l2cache_mem_req_r,
  input  logic [31:0]                     l2cache_mem_addr_r,
  input  logic                            l2cache_mem_size_r,
  input  logic                            l2cache_mem_req_w,
  input  logic [31:0]                     l2cache_mem_addr_w,
  input  logic                            l2cache_mem_size_w,
  input  logic [(32<<offset_width)-1:0]   l2cache_mem_wdata,
  input  logic [3:0]                      l2cache_mem_wstrb,
  input  logic                            l2cache_mem_rdy,
  output logic                            mem_l2cache_addrOK_r,
  output logic                            mem_l2cache_addrOK_w,
  output logic                            mem_l2cache_dataOK,
  output logic [(32<<offset_width)-1:0]   mem_l2cache_rdata,
  output logic                            ram_req,
  output logic                            ram_we,
  output logic [31:0]                     ram_addr,
  output logic [31:0]                     ram_wdata,
  output logic [3:0]                      ram_wstrb,
  input  logic                            ram_rdy,
  input  logic                            ram_rvalid,
  input  logic [31:0]                     ram_rdata
);

  localparam int LINE_W = 32 << offset_width;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;

  logic [2:0]              state;
  logic [offset_width-1:0] cnt;
  logic [31:2]             addr_q;
  logic                    size_q;
  logic [LINE_W-1:0]       wdata_q;
  logic [3:0]              wstrb_q;
  logic [offset_width-1:0] idx;
  logic                    last;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{l2cache_mem_addr_r[1:0], l2cache_mem_addr_w[1:0]};

  // Word accesses stay on their own lane; line accesses walk the lanes with cnt.
  assign idx  = size_q ? addr_q[offset_width+1:2] : cnt;
  assign last = size_q || (cnt == {offset_width{1'b1}});

  always_comb begin
    mem_l2cache_addrOK_w = !rst && (state == IDLE) && l2cache_mem_req_w;
    mem_l2cache_addrOK_r = !rst && (state == IDLE) && !l2cache_mem_req_w && l2cache_mem_req_r;
    mem_l2cache_dataOK   = !rst && (state == RD_RESP) && l2cache_mem_rdy;
    ram_req   = (state == WR) || (state == RD_REQ);
    ram_we    = (state == WR);
    ram_addr  = 32'd0;
    ram_wdata = 32'd0;
    ram_wstrb = 4'h0;
    if ((state == WR) || (state == RD_REQ)) begin
      ram_addr = {addr_q[31:offset_width+2], idx, 2'b00};
    end
    if (state == WR) begin
      ram_wdata = wdata_q[32*idx +: 32];
      ram_wstrb = size_q ? wstrb_q : 4'hF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      addr_q            <= '0;
      size_q            <= 1'b0;
      wdata_q           <= '0;
      wstrb_q           <= 4'h0;
      mem_l2cache_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (l2cache_mem_req_w) begin
            state   <= WR;
            addr_q  <= l2cache_mem_addr_w[31:2];
            size_q  <= l2cache_mem_size_w;
            wdata_q <= l2cache_mem_wdata;
            wstrb_q <= l2cache_mem_wstrb;
          end else if (l2cache_mem_req_r) begin
            state             <= RD_REQ;
            addr_q            <= l2cache_mem_addr_r[31:2];
            size_q            <= l2cache_mem_size_r;
            mem_l2cache_rdata <= '0;
          end
        end
        WR: begin
          if (ram_rdy) begin
            cnt <= cnt + 1'b1;
            if (last) state <= IDLE;
          end
        end
        RD_REQ: begin
          if (ram_rdy) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (ram_rvalid) begin
            mem_l2cache_rdata[32*idx +: 32] <= ram_rdata;
            cnt   <= cnt + 1'b1;
            state <= last ? RD_RESP : RD_REQ;
          end
        end
        RD_RESP: begin
          if (l2cache_mem_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2cache_mem_responder.sv
// tb/tb_l2cache_mem_responder.sv - bench for l2cache_mem_responder
// Random and directed L2 requests checked against a word-memory reference model and a RAM access log.
module tb_l2cache_mem_responder;
  localparam int OW = 2;
  localparam int NW = 1 << OW;
  localparam int LW = 32 << OW;

  logic clk = 1'b0;
  logic rst;
  logic req_r, size_r, req_w, size_w, rdy;
  logic [31:0] addr_r, addr_w;
  logic [LW-1:0] wdata;
  logic [3:0] wstrb;
  logic addr_ok_r, addr_ok_w, data_ok;
  logic [LW-1:0] rdata;
  logic ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0] ram_wstrb;
  logic ram_rdy, ram_rvalid;
  logic [31:0] ram_rdata;

  int total, bad, cyc, rv_cnt, rd_delay_max;
  bit rand_rdy;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          c;
  } acc_t;
  acc_t log_q[$];

  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  l2cache_mem_responder #(.offset_width(OW)) dut (
    .clk(clk), .rst(rst),
    .l2cache_mem_req_r(req_r), .l2cache_mem_addr_r(addr_r), .l2cache_mem_size_r(size_r),
    .l2cache_mem_req_w(req_w), .l2cache_mem_addr_w(addr_w), .l2cache_mem_size_w(size_w),
    .l2cache_mem_wdata(wdata), .l2cache_mem_wstrb(wstrb), .l2cache_mem_rdy(rdy),
    .mem_l2cache_addrOK_r(addr_ok_r), .mem_l2cache_addrOK_w(addr_ok_w),
    .mem_l2cache_dataOK(data_ok), .mem_l2cache_rdata(rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_rdy(ram_rdy), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  function automatic logic [31:0] init_word(logic [31:0] a);
    return a ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] ram_get(logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_get(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] line_base(logic [31:0] a);
    return a & ~32'(LW/8 - 1);
  endfunction

  function automatic logic [LW-1:0] ref_line(logic [31:0] a, bit sz);
    logic [LW-1:0] r;
    r = '0;
    if (sz) r[32*a[OW+1:2] +: 32] = ref_get({a[31:2], 2'b00});
    else for (int i = 0; i < NW; i++) r[32*i +: 32] = ref_get(line_base(a) + 32'(4*i));
    return r;
  endfunction

  function automatic void ref_write(logic [31:0] a, bit sz, logic [LW-1:0] d, logic [3:0] s);
    logic [31:0] b, old, nw;
    if (sz) begin
      b   = {a[31:2], 2'b00};
      old = ref_get(b);
      nw  = d[32*a[OW+1:2] +: 32];
      for (int j = 0; j < 4; j++) if (s[j]) old[8*j +: 8] = nw[8*j +: 8];
      ref_mem[b] = old;
    end else begin
      for (int i = 0; i < NW; i++) ref_mem[line_base(a) + 32'(4*i)] = d[32*i +: 32];
    end
  endfunction

  // RAM model: drives at negedge, observes the upcoming edge's handshakes just before it.
  initial begin
    bit pend;
    int cd;
    logic [31:0] pa, old;
    pend = 0; cd = 0; pa = '0;
    ram_rdy = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;
    forever begin
      @(negedge clk);
      ram_rvalid = 1'b0;
      ram_rdata  = '0;
      ram_rdy    = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend) begin
        if (cd == 0) begin
          ram_rvalid = 1'b1;
          ram_rdata  = ram_get(pa);
          pend = 0;
        end else cd--;
      end
      #4;
      if (rst) pend = 0;
      else begin
        if (ram_rvalid) rv_cnt++;
        if (ram_req && ram_rdy) begin
          log_q.push_back('{ram_we, ram_addr, ram_wdata, ram_wstrb, cyc});
          total++;
          if (pend || ram_addr[1:0] != 2'b00) begin
            bad++;
            $display("FAIL ram_protocol got=pend%0d/addr%h want=idle/aligned", pend, ram_addr);
          end
          if (ram_we) begin
            old = ram_get(ram_addr);
            for (int j = 0; j < 4; j++) if (ram_wstrb[j]) old[8*j +: 8] = ram_wdata[8*j +: 8];
            ram_mem[ram_addr] = old;
          end else begin
            pend = 1;
            pa   = ram_addr;
            cd   = $urandom_range(0, rd_delay_max);
          end
        end
      end
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input bit sz, input logic [LW-1:0] d,
                       input logic [3:0] s, output int c0);
    if (w) begin
      req_w = 1'b1; addr_w = a; size_w = sz; wdata = d; wstrb = s;
    end else begin
      req_r = 1'b1; addr_r = a; size_r = sz;
    end
    c0 = -1;
    for (int n = 0; n < 300; n++) begin
      #4;
      if (w ? addr_ok_w : addr_ok_r) begin
        c0 = cyc;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (c0 < 0) begin
      bad++;
      $display("FAIL accept_timeout got=none want=addrOK_%s", w ? "w" : "r");
    end
    @(negedge clk);
    if (w) begin
      req_w = 1'b0;
      wdata = {NW{$urandom}};
      wstrb = 4'($urandom);
    end else req_r = 1'b0;
  endtask

  task automatic wait_data(input int hold, output logic [LW-1:0] d, output int c);
    c = -1;
    d = '0;
    for (int k = 0; k < 500; k++) begin
      rdy = (k >= hold);
      #4;
      if (data_ok) begin
        c = cyc;
        d = rdata;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (c < 0) begin
      bad++;
      $display("FAIL data_timeout got=none want=dataOK");
    end
    @(negedge clk);
    #4;
    total++;
    if (data_ok !== 1'b0) begin
      bad++;
      $display("FAIL dataok_pulse got=%b want=0", data_ok);
    end
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic wait_log(input int n);
    for (int k = 0; k < 300; k++) begin
      if (log_q.size() >= n) break;
      @(negedge clk);
    end
    total++;
    if (log_q.size() != n) begin
      bad++;
      $display("FAIL log_count got=%0d want=%0d", log_q.size(), n);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if ({addr_ok_r, addr_ok_w, data_ok, ram_req, ram_we} !== 5'b0 || ram_addr !== '0 ||
        ram_wdata !== '0 || ram_wstrb !== '0 || rdata !== '0) begin
      bad++;
      $display("FAIL %s got=ok%b%b%b req%b we%b a%h rd%h want=all_zero", tag, addr_ok_r,
               addr_ok_w, data_ok, ram_req, ram_we, ram_addr, rdata);
    end
  endtask

  task automatic check_reads(input string tag, input logic [31:0] a, input bit sz, input int c0,
                             input bit timed);
    logic [31:0] ea;
    int n;
    n = sz ? 1 : NW;
    total++;
    if (log_q.size() != n) begin
      bad++;
      $display("FAIL %s_count got=%0d want=%0d", tag, log_q.size(), n);
    end
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      ea = sz ? {a[31:2], 2'b00} : line_base(a) + 32'(4*i);
      total++;
      if (log_q[i].we !== 1'b0 || log_q[i].addr !== ea || log_q[i].strb !== 4'h0 ||
          (timed && log_q[i].c != c0 + 1 + 2*i)) begin
        bad++;
        $display("FAIL %s_acc%0d got=we%b a%h s%h c%0d want=we0 a%h s0 c%0d", tag, i,
                 log_q[i].we, log_q[i].addr, log_q[i].strb, log_q[i].c - c0, ea, 1 + 2*i);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #4;
    check_idle_outputs("reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_line_read();
    logic [LW-1:0] got, exp;
    int c0, c;
    rand_rdy = 0; rd_delay_max = 0;
    for (int i = 0; i < NW; i++) begin
      ram_mem[32'h1230 + 32'(4*i)] = 32'hA0 + 32'(i);
      ref_mem[32'h1230 + 32'(4*i)] = 32'hA0 + 32'(i);
      exp[32*i +: 32] = 32'hA0 + 32'(i);
    end
    log_q.delete();
    issue(0, 32'h1238, 0, '0, 4'h0, c0);
    wait_data(0, got, c);
    total++;
    if (c != c0 + 1 + 2*NW) begin
      bad++;
      $display("FAIL lr_dataok_cycle got=%0d want=%0d", c - c0, 1 + 2*NW);
    end
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL lr_rdata got=%h want=%h", got, exp);
    end
    check_reads("lr", 32'h1238, 0, c0, 1);
  endtask

  task automatic test_write_back_to_back();
    logic [LW-1:0] d, dw;
    logic [31:0] ed;
    int c0, c1;
    rand_rdy = 0;
    for (int i = 0; i < NW; i++) d[32*i +: 32] = 32'hD0 + 32'(i);
    dw = {NW{$urandom}};
    dw[63:32] = 32'hBEEF_0000;
    log_q.delete();
    issue(1, 32'h2000, 0, d, 4'h0, c0);
    issue(1, 32'h3006, 1, dw, 4'b1100, c1);
    ref_write(32'h2000, 0, d, 4'h0);
    ref_write(32'h3006, 1, dw, 4'b1100);
    total++;
    if (c1 != c0 + NW + 1) begin
      bad++;
      $display("FAIL wr_next_accept got=%0d want=%0d", c1 - c0, NW + 1);
    end
    wait_log(NW + 1);
    for (int i = 0; i < NW && i < log_q.size(); i++) begin
      ed = 32'hD0 + 32'(i);
      total++;
      if (log_q[i].we !== 1'b1 || log_q[i].addr !== 32'h2000 + 32'(4*i) ||
          log_q[i].data !== ed || log_q[i].strb !== 4'hF || log_q[i].c != c0 + 1 + i) begin
        bad++;
        $display("FAIL lw_acc%0d got=a%h d%h s%h c%0d want=a%h d%h sF c%0d", i, log_q[i].addr,
                 log_q[i].data, log_q[i].strb, log_q[i].c - c0, 32'h2000 + 32'(4*i), ed, 1 + i);
      end
    end
    if (log_q.size() > NW) begin
      total++;
      if (log_q[NW].we !== 1'b1 || log_q[NW].addr !== 32'h3004 ||
          log_q[NW].data !== 32'hBEEF_0000 || log_q[NW].strb !== 4'b1100 ||
          log_q[NW].c != c1 + 1) begin
        bad++;
        $display("FAIL ww_acc got=a%h d%h s%h c%0d want=a3004 dBEEF0000 sC c1", log_q[NW].addr,
                 log_q[NW].data, log_q[NW].strb, log_q[NW].c - c1);
      end
    end
  endtask

  task automatic test_priority();
    logic [LW-1:0] d, got;
    int cw, cr, c;
    rand_rdy = 0; rd_delay_max = 0;
    d = {NW{$urandom}};
    log_q.delete();
    req_w = 1'b1; addr_w = 32'h4000; size_w = 1'b0; wdata = d; wstrb = 4'h0;
    req_r = 1'b1; addr_r = 32'h4008; size_r = 1'b0;
    #4;
    cw = cyc;
    total++;
    if (addr_ok_w !== 1'b1 || addr_ok_r !== 1'b0) begin
      bad++;
      $display("FAIL prio_accept got=w%b r%b want=w1 r0", addr_ok_w, addr_ok_r);
    end
    ref_write(32'h4000, 0, d, 4'h0);
    @(negedge clk);
    req_w = 1'b0;
    wdata = '0;
    cr = -1;
    for (int k = 0; k < 50; k++) begin
      #4;
      if (addr_ok_r) begin
        cr = cyc;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (cr != cw + NW + 1) begin
      bad++;
      $display("FAIL prio_read_accept got=%0d want=%0d", cr - cw, NW + 1);
    end
    @(negedge clk);
    req_r = 1'b0;
    wait_data(0, got, c);
    total++;
    if (got !== d) begin
      bad++;
      $display("FAIL prio_rdata got=%h want=%h", got, d);
    end
    total++;
    if (log_q.size() != 2*NW || log_q[NW-1].we !== 1'b1 || log_q[NW].we !== 1'b0) begin
      bad++;
      $display("FAIL prio_order got=n%0d want=%0d_writes_then_reads", log_q.size(), NW);
    end
  endtask

  task automatic test_stalls();
    logic [LW-1:0] exp;
    int c0;
    bit seen;
    rand_rdy = 1; rd_delay_max = 3;
    exp = ref_line(32'h5004, 0);
    log_q.delete();
    rv_cnt = 0;
    rdy = 1'b0;
    issue(0, 32'h5004, 0, '0, 4'h0, c0);
    seen = 0;
    for (int k = 0; k < 400; k++) begin
      #4;
      if (rv_cnt >= NW) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL stall_rvalid got=%0d want=%0d", rv_cnt, NW);
    end
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      rdy = 1'b0;
      #4;
      total++;
      if (data_ok !== 1'b0 || rdata !== exp) begin
        bad++;
        $display("FAIL stall_hold%0d got=ok%b %h want=ok0 %h", h, data_ok, rdata, exp);
      end
    end
    @(negedge clk);
    rdy = 1'b1;
    #4;
    total++;
    if (data_ok !== 1'b1 || rdata !== exp) begin
      bad++;
      $display("FAIL stall_release got=ok%b %h want=ok1 %h", data_ok, rdata, exp);
    end
    @(negedge clk);
    #4;
    total++;
    if (data_ok !== 1'b0) begin
      bad++;
      $display("FAIL stall_pulse got=%b want=0", data_ok);
    end
    @(negedge clk);
    rdy = 1'b0;
    check_reads("st", 32'h5004, 0, c0, 0);
    rand_rdy = 0;
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] got;
    int c0, c;
    rand_rdy = 0; rd_delay_max = 0;
    log_q.delete();
    issue(0, 32'h6000, 0, '0, 4'h0, c0);
    for (int k = 0; k < 100; k++) begin
      #4;
      if (log_q.size() >= 3) break;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    req_r = 1'b1; addr_r = 32'h6000; size_r = 1'b0;
    #1;
    check_idle_outputs("rstmid_async");
    @(negedge clk);
    #4;
    check_idle_outputs("rstmid_held");
    @(negedge clk);
    log_q.delete();
    rst = 1'b0;
    #4;
    c0 = cyc;
    total++;
    if (addr_ok_r !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_accept got=%b want=1", addr_ok_r);
    end
    @(negedge clk);
    req_r = 1'b0;
    wait_data(0, got, c);
    total++;
    if (got !== ref_line(32'h6000, 0) || c != c0 + 1 + 2*NW) begin
      bad++;
      $display("FAIL rstmid_read got=%h c%0d want=%h c%0d", got, c - c0, ref_line(32'h6000, 0),
               1 + 2*NW);
    end
    check_reads("rm", 32'h6000, 0, c0, 1);
  endtask

  task automatic test_random();
    logic [LW-1:0] d, got, exp;
    logic [31:0] a, ea, ed;
    logic [3:0] s, es;
    bit w, sz;
    int c0, c, n, k;
    rd_delay_max = 2;
    for (int t = 0; t < 30; t++) begin
      rand_rdy = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      sz = 1'($urandom_range(0, 1));
      a  = 32'h8000 | $urandom_range(0, 255);
      for (int i = 0; i < NW; i++) d[32*i +: 32] = $urandom;
      s  = 4'($urandom_range(0, 15));
      n  = sz ? 1 : NW;
      k  = int'(a[OW+1:2]);
      log_q.delete();
      if (w) begin
        issue(1, a, sz, d, s, c0);
        wait_log(n);
        for (int i = 0; i < n && i < log_q.size(); i++) begin
          ea = sz ? {a[31:2], 2'b00} : line_base(a) + 32'(4*i);
          ed = sz ? d[32*k +: 32] : d[32*i +: 32];
          es = sz ? s : 4'hF;
          total++;
          if (log_q[i].we !== 1'b1 || log_q[i].addr !== ea || log_q[i].data !== ed ||
              log_q[i].strb !== es) begin
            bad++;
            $display("FAIL rnd%0d_wr%0d got=a%h d%h s%h want=a%h d%h s%h", t, i, log_q[i].addr,
                     log_q[i].data, log_q[i].strb, ea, ed, es);
          end
        end
        ref_write(a, sz, d, s);
      end else begin
        exp = ref_line(a, sz);
        issue(0, a, sz, '0, 4'h0, c0);
        wait_data(int'($urandom_range(0, 3)), got, c);
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL rnd%0d_rdata got=%h want=%h", t, got, exp);
        end
        check_reads("rnd", a, sz, c0, 0);
      end
    end
    rand_rdy = 0;
  endtask

  initial begin
    total = 0; bad = 0; rv_cnt = 0;
    rand_rdy = 0; rd_delay_max = 0;
    rst = 1'b1;
    req_r = 1'b0; addr_r = '0; size_r = 1'b0;
    req_w = 1'b0; addr_w = '0; size_w = 1'b0;
    wdata = '0; wstrb = '0; rdy = 1'b0;
    test_reset();
    test_line_read();
    test_write_back_to_back();
    test_priority();
    test_stalls();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2cache_mem_responder.md
# l2cache_mem_responder

Memory-side responder for the L2 cache's refill/writeback port. Accepts line or single-word (strongly-ordered) read and write requests from the L2 main FSM using the req/addrOK/rdy/dataOK handshake. Serializes each request into word accesses on a one-outstanding, word-wide backing-RAM port. Sits between the L2 cache and main memory / the SoC memory bridge.

## Interface
- offset_width, 2, log2(words per line); line width L = 32<<offset_width (128 by default)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- l2cache_mem_req_r  in  1  read request; held by L2 until mem_l2cache_addrOK_r
- l2cache_mem_addr_r  in  32  read byte address
- l2cache_mem_size_r  in  1  0 = line read, 1 = single word (SUC)
- l2cache_mem_req_w  in  1  write request; held until mem_l2cache_addrOK_w
- l2cache_mem_addr_w  in  32  write byte address
- l2cache_mem_size_w  in  1  0 = line write, 1 = single word
- l2cache_mem_wdata  in  L  write line; word i at bits [32i+31:32i]
- l2cache_mem_wstrb  in  4  byte strobes, word writes only
- l2cache_mem_rdy  in  1  L2 ready to take read data
- mem_l2cache_addrOK_r  out  1  read accepted, 1-cycle pulse
- mem_l2cache_addrOK_w  out  1  write accepted and data captured, 1-cycle pulse
- mem_l2cache_dataOK  out  1  read data valid, 1-cycle pulse
- mem_l2cache_rdata  out  L  read line
- ram_req  out  1  word access request
- ram_we  out  1  1 = write
- ram_addr  out  32  word-aligned byte address (bits [1:0] = 0)
- ram_wdata  out  32  write word
- ram_wstrb  out  4  byte strobes
- ram_rdy  in  1  RAM accepts access this cycle (handshake on ram_req && ram_rdy)
- ram_rvalid  in  1  read word returned
- ram_rdata  in  32  read word

## Operation
- States: IDLE, WR, RD_REQ, RD_WAIT, RD_RESP.
- IDLE with req_w: addrOK_w=1 (Mealy). Latch addr, wdata, size, wstrb. Go to WR. req_w takes priority over req_r; addrOK_r stays 0 that cycle.
- IDLE with req_r only: addrOK_r=1 (Mealy). Latch addr and size. Clear rdata buffer. Go to RD_REQ.
- Line base = addr with bits [offset_width+1:0] cleared. Word count N = 2^offset_width for line accesses, 1 for word accesses.
- Word access address: addr with bits [1:0] cleared. Data lane k = addr[offset_width+1:2].
- WR: ram_req=1, ram_we=1, ram_addr = base + 4*cnt. Line writes use wstrb=4'hF and wdata word cnt. Word writes use the latched wstrb and lane k.
  - cnt increments on each ram_rdy.
  - After the last accepted word, go to IDLE.
- RD_REQ: ram_req=1, ram_we=0, ram_wstrb=0. On ram_rdy go to RD_WAIT.
- RD_WAIT: on ram_rvalid, store ram_rdata into rdata word cnt (word access: lane k; other lanes 0). Then go to RD_REQ for the next word, or to RD_RESP after the last.
- RD_RESP: when l2cache_mem_rdy=1, dataOK=1 for one cycle, then IDLE. While rdy=0, hold state and rdata.
- Busy (any non-IDLE state): addrOK_r and addrOK_w stay 0; pending L2 requests wait.
- Writes are posted. Ordering is still guaranteed: no read is accepted until the WR drain completes, so a read-after-writeback sees the new data.
- ram_rvalid outside RD_WAIT is ignored.
- Reset values: state IDLE, cnt 0, all outputs 0 (rdata 0). Reset mid-operation aborts the transaction; ram_req deasserts immediately (asynchronously).

## Timing
- Cycle 0 = addrOK cycle.
- Line read with ram_rdy=1 and rvalid exactly 1 cycle after acceptance: ram_req in cycles 1,3,5,7. rvalid in 2,4,6,8. dataOK in cycle 9 if rdy=1 (in general, cycle 1+2N).
- Line write with ram_rdy=1: ram writes in cycles 1..N. IDLE in cycle N+1; next addrOK is possible in cycle N+1.
- ram_rdy stalls extend the current state cycle-for-cycle.
- rdata is stable from entry to RD_RESP until the next read is accepted.

## Test plan
- Line read 0x0000_1238: ram_addr sequence 0x1230, 0x1234, 0x1238, 0x123C; RAM returns 0xA0..0xA3 -> dataOK in cycle 9, rdata = {A3,A2,A1,A0}.
- Line write 0x0000_2000, wdata {D3,D2,D1,D0} -> addrOK_w in cycle 0; ram writes 0x2000..0x200C with strb F and data D0..D3 in cycles 1–4; IDLE in cycle 5.
- Word write addr 0x3006, wstrb 4'b1100, wdata lane1 = 0xBEEF0000 -> single ram write: addr 0x3004, strb 1100, data 0xBEEF0000.
- req_r and req_w asserted together in IDLE -> addrOK_w only; the write drains fully, then addrOK_r; the read of the same line returns the written data.
- rdy held 0 for 5 cycles in RD_RESP, ram_rdy toggled 0/1 in RD_REQ -> dataOK only on the first rdy=1 cycle; rdata unchanged throughout.
- rst pulsed during RD_WAIT after 2 words -> all outputs 0 within the reset cycle; the next req_r is accepted cleanly with a fresh 4-word sequence.
